trace_capture_buffer: RTL

- Parametrised on-chip trace capture for the RISCV_PROCESSOR commit stream (pc, instr, alu_out).
- Replaces free-running $monitor observation with a triggered, circular pre/post-trigger buffer.
- Captured entries are read back oldest-first over a valid/ready stream by a bench or debug port.
- Sits beside the core as a passive observer; no influence on core execution.

---
 rtl/trace_capture_buffer.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/trace_capture_buffer.sv
// Triggered circular trace buffer for the core commit stream (pc, instr, alu_out).
// Keeps up to PRE_TRIG entries before the trigger, then plays the window back oldest-first.
module trace_capture_buffer #(
    parameter int XLEN     = 32,
    parameter int DEPTH    = 16,
    parameter int PRE_TRIG = 8,
    parameter int AW       = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            sample_valid,
    input  logic [XLEN-1:0] pc,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] alu_out,
    input  logic            arm,
    input  logic            abort,
    input  logic [1:0]      trig_mode,
    input  logic [XLEN-1:0] trig_pc,
    input  logic [31:0]     trig_instr,
    input  logic [31:0]     trig_mask,
    input  logic            ext_trig,
    output logic [1:0]      state,
    output logic            rd_valid,
    input  logic            rd_ready,
    output logic [XLEN-1:0] rd_pc,
    output logic [31:0]     rd_instr,
    output logic [XLEN-1:0] rd_alu,
    output logic            rd_last,
    output logic [AW:0]     rd_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PRE  = 2'd1,
        S_POST = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [AW:0]   POST_N  = (AW+1)'(DEPTH - PRE_TRIG);
    localparam logic [AW:0]   PRE_MAX = (AW+1)'(PRE_TRIG);
    localparam logic [AW:0]   ONE     = (AW+1)'(1);
    localparam logic [AW-1:0] P1      = AW'(1);

    state_t r_state;
    state_t w_next;

    logic [XLEN-1:0] r_mem_pc    [DEPTH];
    logic [31:0]     r_mem_instr [DEPTH];
    logic [XLEN-1:0] r_mem_alu   [DEPTH];

    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_pre_cnt;
    logic [AW:0]     r_post_cnt;
    logic [AW:0]     r_rd_count;
    logic [AW:0]     r_rd_idx;
    logic            r_rd_valid;
    logic            r_rd_last;
    logic [XLEN-1:0] r_rd_pc;
    logic [31:0]     r_rd_instr;
    logic [XLEN-1:0] r_rd_alu;

    logic            w_trig;
    logic            w_wr_en;
    logic            w_hs;
    logic            w_load;
    logic            w_enter_done;
    logic [AW:0]     w_fill;
    logic [AW-1:0]   w_rd_start;

    always_comb begin
        w_trig = 1'b0;
        unique case (trig_mode)
            2'd0: w_trig = 1'b1;
            2'd1: w_trig = (pc == trig_pc);
            2'd2: w_trig = ((instr & trig_mask) == (trig_instr & trig_mask));
            2'd3: w_trig = ext_trig;
        endcase
    end

    assign w_wr_en      = sample_valid && (r_state == S_PRE || r_state == S_POST);
    assign w_hs         = r_rd_valid && rd_ready;
    assign w_load       = (r_state == S_DONE) && (!r_rd_valid || (w_hs && !r_rd_last));
    assign w_enter_done = (r_state != S_DONE) && (w_next == S_DONE);
    assign w_fill       = r_pre_cnt + POST_N;
    // The window ends at the entry written on the DONE-entry edge, so the
    // oldest kept entry sits rd_count slots behind the advanced write pointer.
    assign w_rd_start   = r_wr_ptr + P1 - w_fill[AW-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (abort) begin
            w_next = S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE: if (arm) w_next = S_PRE;
                S_PRE: begin
                    if (sample_valid && w_trig)
                        w_next = (POST_N == ONE) ? S_DONE : S_POST;
                end
                S_POST: begin
                    if (sample_valid && (r_post_cnt + ONE == POST_N))
                        w_next = S_DONE;
                end
                S_DONE: if (w_hs && r_rd_last) w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem_pc[r_wr_ptr]    <= pc;
            r_mem_instr[r_wr_ptr] <= instr;
            r_mem_alu[r_wr_ptr]   <= alu_out;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_pre_cnt  <= '0;
            r_post_cnt <= '0;
            r_rd_count <= '0;
            r_rd_idx   <= '0;
            r_rd_valid <= 1'b0;
            r_rd_last  <= 1'b0;
            r_rd_pc    <= '0;
            r_rd_instr <= '0;
            r_rd_alu   <= '0;
        end else if (abort) begin
            r_rd_valid <= 1'b0;
            r_rd_last  <= 1'b0;
            r_rd_count <= '0;
        end else begin
            if (r_state == S_IDLE && arm) begin
                r_wr_ptr   <= '0;
                r_pre_cnt  <= '0;
                r_post_cnt <= '0;
                r_rd_count <= '0;
            end
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + P1;
                if (r_state == S_POST)
                    r_post_cnt <= r_post_cnt + ONE;
                else if (w_trig)
                    r_post_cnt <= ONE;
                else if (r_pre_cnt != PRE_MAX)
                    r_pre_cnt <= r_pre_cnt + ONE;
            end
            if (w_enter_done) begin
                r_rd_count <= w_fill;
                r_rd_ptr   <= w_rd_start;
                r_rd_idx   <= ONE;
            end
            // One path serves both the first fetch and each accepted entry.
            if (w_load) begin
                r_rd_pc    <= r_mem_pc[r_rd_ptr];
                r_rd_instr <= r_mem_instr[r_rd_ptr];
                r_rd_alu   <= r_mem_alu[r_rd_ptr];
                r_rd_valid <= 1'b1;
                r_rd_last  <= (r_rd_idx == r_rd_count);
                r_rd_ptr   <= r_rd_ptr + P1;
                r_rd_idx   <= r_rd_idx + ONE;
            end else if (w_hs) begin
                r_rd_valid <= 1'b0;
                r_rd_last  <= 1'b0;
            end
        end
    end

    assign state    = r_state;
    assign rd_valid = r_rd_valid;
    assign rd_last  = r_rd_last;
    assign rd_pc    = r_rd_pc;
    assign rd_instr = r_rd_instr;
    assign rd_alu   = r_rd_alu;
    assign rd_count = r_rd_count;

endmodule
